filter_result_streamer: RTL
===========================

Name: filter_result_streamer

Overview:
- Reader at the far end of the filter block's result interface.
- Watches the filter's flat result bus and its done flag. When done rises, it walks every element in filter→row→column order.
- Each element is requantized: optional ReLU, arithmetic right shift, saturation to BIT_SIZE signed.
- Elements leave one per beat on a valid/ready stream toward pooling, the next layer, or a DMA writer.

Parameters:
- FILTER_SIZE, 15, number of filters in the result bus
- FILTER_COUNTER_BIT_SIZE, 4, width of filter index, ceil(log2(FILTER_SIZE))
- BIT_SIZE, 9, output element width (signed)
- SUBKERNEL_OUT_BIT, 24, accumulator base width
- CHANNEL_EXTENSION_BIT, 2, accumulator extension; ACC_BIT = SUBKERNEL_OUT_BIT + CHANNEL_EXTENSION_BIT
- OUTPUT_WIDTH, 27, columns per filter map
- OUTPUT_HEIGHT, 27, rows per filter map
- POS_BIT, 5, width of row/column indices, ceil(log2(max(OUTPUT_WIDTH, OUTPUT_HEIGHT)))
- SHIFT, 0, arithmetic right-shift applied before saturation
- RELU, 1, 1 = negative values are forced to 0 before the shift

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- enable  in  1  when 0, no new element is loaded; a held beat stays held
- filter_result  in  FILTER_SIZE*ACC_BIT*OUTPUT_WIDTH*OUTPUT_HEIGHT  flat signed results; element e occupies bits [(e+1)*ACC_BIT-1 : e*ACC_BIT], e = f*OW*OH + r*OW + c
- filter_done  in  1  producer done level; must stay high with the bus stable for the whole stream
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accept
- out_data  out  BIT_SIZE  requantized signed element
- out_filter  out  FILTER_COUNTER_BIT_SIZE  filter index of the beat
- out_row  out  POS_BIT  row index of the beat
- out_col  out  POS_BIT  column index of the beat
- out_last  out  1  beat is the final element of the final filter
- busy  out  1  state is STREAM
- stream_done  out  1  full stream delivered; held high until the state returns to IDLE
- sat_count  out  16  number of clipped elements in the current stream; saturates at 0xFFFF

Behaviour:
- Reset values: out_valid=0, out_data=0, out_filter/out_row/out_col=0, out_last=0, busy=0, stream_done=0, sat_count=0, state=IDLE, done_q=0.
- done_q registers filter_done every cycle; start = filter_done & ~done_q.

State machine:
- IDLE: on start → STREAM, clear counters and sat_count.
- STREAM: a load happens when enable & (~out_valid | out_ready) & elements remain.
  - A load registers the element at counters (f,r,c) into the out_* registers, sets out_valid, then advances c, wrapping to r, wrapping to f.
  - Accepting the last beat (out_valid & out_ready & out_last) → DONE, out_valid=0 the next cycle.
- DONE: stream_done=1. When filter_done=0 → IDLE, stream_done=0.
- Abort: filter_done=0 while in STREAM → IDLE on the next edge. out_valid drops, stream_done stays 0, any pending beat is discarded.

Handshake and timing:
- Latency: start sampled at edge N gives first out_valid after edge N+1.
- With out_ready held high, throughput is 1 beat/cycle, so the stream takes FILTER_SIZE*OW*OH beats.
- While out_valid=1 and out_ready=0, all out_* registers hold stable.
- enable=0 never drops a valid beat; it only blocks the next load.

Arithmetic (ACC_BIT signed):
- v = element; if RELU and v<0, v=0.
- s = v >>> SHIFT.
- If s > 2^(BIT_SIZE-1)-1, output max; if s < -2^(BIT_SIZE-1), output min. Either case increments sat_count, which sticks at 0xFFFF.

Boundaries:
- A rising filter_done in DONE cannot occur without an intervening low, so exactly one stream runs per done pulse.
- A start in STREAM is impossible because done is already high.
- OUTPUT_WIDTH=1 or OUTPUT_HEIGHT=1 wraps correctly.
- FILTER_SIZE=1: out_last is asserted on element OW*OH-1.

Decomposition:
- Shared package cnn_pkg:
  - ACC_BIT derivation
  - saturation limit constants per BIT_SIZE
  - state encoding localparams: IDLE=0, STREAM=1, DONE=2
- Sub-module requantize (combinational ReLU/shift/saturate; outputs value and clip flag), reusable by future pooling blocks.
- The element index mux and the counters stay in the top module.

Test Plan (FILTER_SIZE=2, OW=OH=2, BIT_SIZE=9, ACC_BIT=26, RELU=1, SHIFT=0 unless stated):
- Elements 0..7 = 1..8; raise filter_done with out_ready=1 → 8 consecutive beats: data 1..8, (f,r,c) from (0,0,0) to (1,1,1), out_last only on beat 8, then stream_done=1.
- Elements {-5, 300, -300, 255, …}, RELU=1 → out_data 0, 255, 0, 255; sat_count=1. With RELU=0: 255 and -256, sat_count=2.
- SHIFT=2, element 1023 → 255; element 1024 → 255 with sat_count increment; element -9 with RELU=0 → -3.
- Toggle out_ready 1,0,0,1… → no duplicate or lost beats; out_* stable during stalls; enable=0 for 3 cycles mid-stream → only a pause.
- Drop filter_done after beat 3 → out_valid=0 within 1 cycle, stream_done stays 0. Re-raise → stream restarts at (0,0,0).
- Assert reset low mid-beat → all outputs 0 immediately (asynchronous). Release reset with filter_done already high → no stream starts until a fresh rising edge.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: accumulator width derivation, signed saturation
// limits for a given output width, and the result-streamer state encoding.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } stream_state_t;

  function automatic int acc_bit(input int subkernel_out_bit, input int channel_extension_bit);
    return subkernel_out_bit + channel_extension_bit;
  endfunction

  // Largest value representable in a signed field of the given width.
  function automatic longint sat_hi(input int bits);
    return (longint'(1) <<< (bits - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed field of the given width.
  function automatic longint sat_lo(input int bits);
    return -(longint'(1) <<< (bits - 1));
  endfunction

endpackage

// File: rtl/filter_result_streamer_if.sv
// Valid/ready element stream leaving the filter result streamer, tagged with the
// filter/row/column position of each element and an end-of-stream marker.
interface filter_result_streamer_if #(
  parameter int BIT_SIZE                = 9,
  parameter int FILTER_COUNTER_BIT_SIZE = 4,
  parameter int POS_BIT                 = 5
);

  logic                               out_valid;
  logic                               out_ready;
  logic [BIT_SIZE-1:0]                out_data;
  logic [FILTER_COUNTER_BIT_SIZE-1:0] out_filter;
  logic [POS_BIT-1:0]                 out_row;
  logic [POS_BIT-1:0]                 out_col;
  logic                               out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_filter,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_filter,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/filter_result_streamer_requantize.sv
// Combinational requantizer: optional ReLU, arithmetic right shift, then signed
// saturation to BIT_SIZE with a flag raised whenever the value had to be clipped.
module requantize
  import cnn_pkg::*;
#(
  parameter int ACC_BIT  = 26,
  parameter int BIT_SIZE = 9,
  parameter int SHIFT    = 0,
  parameter int RELU     = 1
) (
  input  logic signed [ACC_BIT-1:0]  value,
  output logic signed [BIT_SIZE-1:0] data,
  output logic                       clip
);

  localparam logic signed [ACC_BIT-1:0] HI = ACC_BIT'(sat_hi(BIT_SIZE));
  localparam logic signed [ACC_BIT-1:0] LO = ACC_BIT'(sat_lo(BIT_SIZE));

  logic signed [ACC_BIT-1:0] rect;
  logic signed [ACC_BIT-1:0] shifted;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    rect    = value;
    data    = '0;
    clip    = 1'b0;
    if ((RELU != 0) && (value < 0)) begin
      rect = '0;
    end
    shifted = rect >>> SHIFT;
    if (shifted > HI) begin
      data = BIT_SIZE'(HI);
      clip = 1'b1;
    end else if (shifted < LO) begin
      data = BIT_SIZE'(LO);
      clip = 1'b1;
    end else begin
      data = shifted[BIT_SIZE-1:0];
    end
  end

endmodule

// File: rtl/filter_result_streamer.sv
// Walks the filter block's flat result bus in filter->row->column order once per
// rising filter_done, requantizes each element and emits it on a valid/ready stream.
module filter_result_streamer
  import cnn_pkg::*;
#(
  parameter int FILTER_SIZE             = 15,
  parameter int FILTER_COUNTER_BIT_SIZE = 4,
  parameter int BIT_SIZE                = 9,
  parameter int SUBKERNEL_OUT_BIT       = 24,
  parameter int CHANNEL_EXTENSION_BIT   = 2,
  parameter int OUTPUT_WIDTH            = 27,
  parameter int OUTPUT_HEIGHT           = 27,
  parameter int POS_BIT                 = 5,
  parameter int SHIFT                   = 0,
  parameter int RELU                    = 1,
  localparam int ACC_BIT = acc_bit(SUBKERNEL_OUT_BIT, CHANNEL_EXTENSION_BIT),
  localparam int ELEMS   = FILTER_SIZE * OUTPUT_WIDTH * OUTPUT_HEIGHT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [ELEMS*ACC_BIT-1:0]   filter_result,
  input  logic                       filter_done,
  filter_result_streamer_if.master   stream,
  output logic                       busy,
  output logic                       stream_done,
  output logic [15:0]                sat_count
);

  localparam int MAP_SIZE = OUTPUT_WIDTH * OUTPUT_HEIGHT;
  localparam int IDX_W    = $clog2(ELEMS + 1);

  localparam logic [FILTER_COUNTER_BIT_SIZE-1:0] F_LAST = FILTER_COUNTER_BIT_SIZE'(FILTER_SIZE - 1);
  localparam logic [POS_BIT-1:0]                 R_LAST = POS_BIT'(OUTPUT_HEIGHT - 1);
  localparam logic [POS_BIT-1:0]                 C_LAST = POS_BIT'(OUTPUT_WIDTH - 1);

  stream_state_t state;
  stream_state_t state_next;

  logic                               done_q;
  logic                               armed;
  logic                               start;
  logic                               remain;
  logic                               load;
  logic                               accept;
  logic                               at_last;
  logic [FILTER_COUNTER_BIT_SIZE-1:0] f_cnt;
  logic [POS_BIT-1:0]                 r_cnt;
  logic [POS_BIT-1:0]                 c_cnt;
  logic [IDX_W-1:0]                   elem_idx;
  logic signed [ACC_BIT-1:0]          elem;
  logic signed [BIT_SIZE-1:0]         q_data;
  logic                               q_clip;

  // A done level already high when reset releases is not a rising edge, so start
  // stays masked until one full cycle of done history has been captured.
  assign start   = filter_done & ~done_q & armed;
  assign accept  = stream.out_valid & stream.out_ready;
  assign at_last = (f_cnt == F_LAST) && (r_cnt == R_LAST) && (c_cnt == C_LAST);
  assign load    = (state == STREAM) & filter_done & enable & remain
                 & (~stream.out_valid | stream.out_ready);

  assign elem_idx = IDX_W'(f_cnt) * IDX_W'(MAP_SIZE)
                  + IDX_W'(r_cnt) * IDX_W'(OUTPUT_WIDTH)
                  + IDX_W'(c_cnt);
  assign elem     = filter_result[elem_idx*ACC_BIT +: ACC_BIT];

  requantize #(
    .ACC_BIT  (ACC_BIT),
    .BIT_SIZE (BIT_SIZE),
    .SHIFT    (SHIFT),
    .RELU     (RELU)
  ) u_requantize (
    .value (elem),
    .data  (q_data),
    .clip  (q_clip)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = STREAM;
      end
      STREAM: begin
        if (!filter_done)                  state_next = IDLE;
        else if (accept && stream.out_last) state_next = DONE;
      end
      DONE: begin
        if (!filter_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == STREAM);
    stream_done = (state == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_q            <= 1'b0;
      armed             <= 1'b0;
      remain            <= 1'b0;
      f_cnt             <= '0;
      r_cnt             <= '0;
      c_cnt             <= '0;
      sat_count         <= '0;
      stream.out_valid  <= 1'b0;
      stream.out_data   <= '0;
      stream.out_filter <= '0;
      stream.out_row    <= '0;
      stream.out_col    <= '0;
      stream.out_last   <= 1'b0;
    end else begin
      done_q <= filter_done;
      armed  <= 1'b1;

      if (state == IDLE && start) begin
        f_cnt     <= '0;
        r_cnt     <= '0;
        c_cnt     <= '0;
        sat_count <= '0;
        remain    <= 1'b1;
      end

      if (state == STREAM && !filter_done) begin
        // Abort: the pending beat is discarded and nothing more is loaded.
        stream.out_valid <= 1'b0;
        remain           <= 1'b0;
      end else if (load) begin
        stream.out_valid  <= 1'b1;
        stream.out_data   <= q_data;
        stream.out_filter <= f_cnt;
        stream.out_row    <= r_cnt;
        stream.out_col    <= c_cnt;
        stream.out_last   <= at_last;
        remain            <= ~at_last;
        if (q_clip && (sat_count != 16'hFFFF)) begin
          sat_count <= sat_count + 16'd1;
        end
        if (c_cnt == C_LAST) begin
          c_cnt <= '0;
          if (r_cnt == R_LAST) begin
            r_cnt <= '0;
            f_cnt <= (f_cnt == F_LAST) ? '0 : f_cnt + FILTER_COUNTER_BIT_SIZE'(1);
          end else begin
            r_cnt <= r_cnt + POS_BIT'(1);
          end
        end else begin
          c_cnt <= c_cnt + POS_BIT'(1);
        end
      end else if (accept) begin
        stream.out_valid <= 1'b0;
      end
    end
  end

endmodule
